// File: rtl/epcs_flash_responder.sv
// EPCS serial-flash responder (flash side of the EPCS link).
// Oversamples the master's dclk/sce/sdo in the clk_clk domain and decodes the
// READ (0x03), READ_STATUS (0x05) and READ_ID (0xAB) commands. Read data comes
// from an external byte-wide memory and is shifted out MSB first on epcs_data0.
// All other commands are ignored until chip select is released.
//
// Ports:
//   clk_clk, reset_reset        system clock, sync active-high reset
//   epcs_dclk/sce/sdo           serial link from master (mode 0, sce low active)
//   epcs_data0, epcs_data0_oe   serial data back to master and its drive enable
//   mem_addr, mem_rd, mem_rdata backing memory port (rdata valid 1 cycle after rd)
//   cmd_code                    last complete command byte (debug)
//   busy                        synchronized chip select, inverted
module epcs_flash_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [7:0] SILICON_ID = 8'h12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  epcs_dclk,
  input  logic                  epcs_sce,
  input  logic                  epcs_sdo,
  output logic                  epcs_data0,
  output logic                  epcs_data0_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            cmd_code,
  output logic                  busy
);

  // Input shift register only needs to keep the address bits we use (and at
  // least the 8 command bits); higher flash address bits fall off the top.
  localparam int SW = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] dclk_sync, sce_sync, sdo_sync;
  logic dclk_s, sce_s, sdo_s, dclk_q;
  logic rise, fall;

  // sce chain resets high so a reset never looks like a new selection.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      dclk_sync <= '0;
      sce_sync  <= '1;
      sdo_sync  <= '0;
      dclk_q    <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], epcs_dclk};
      sce_sync  <= {sce_sync[SYNC_STAGES-2:0], epcs_sce};
      sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], epcs_sdo};
      dclk_q    <= dclk_s;
    end
  end

  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign sce_s  = sce_sync[SYNC_STAGES-1];
  assign sdo_s  = sdo_sync[SYNC_STAGES-1];
  assign rise   = dclk_s & ~dclk_q;
  assign fall   = ~dclk_s & dclk_q;

  state_t        state;
  logic [4:0]    bit_cnt;
  logic [SW-1:0] shift_in;
  logic [SW-1:0] shift_next;
  logic [7:0]    cur_byte, nxt_byte;
  logic [2:0]    obit, rbit;
  logic          read_mode, first_byte, rd_q;

  assign shift_next = {shift_in[SW-2:0], sdo_s};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      epcs_data0    <= 1'b0;
      epcs_data0_oe <= 1'b0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      cmd_code      <= 8'h00;
      busy          <= 1'b0;
      bit_cnt       <= '0;
      shift_in      <= '0;
      cur_byte      <= 8'h00;
      nxt_byte      <= 8'h00;
      obit          <= '0;
      rbit          <= '0;
      read_mode     <= 1'b0;
      first_byte    <= 1'b0;
      rd_q          <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      busy   <= ~sce_s;
      rd_q   <= mem_rd;
      if (sce_s) begin
        // Deselect wins over everything, including a same-cycle dclk edge.
        state         <= IDLE;
        epcs_data0    <= 1'b0;
        epcs_data0_oe <= 1'b0;
        bit_cnt       <= '0;
        shift_in      <= '0;
        obit          <= '0;
        rbit          <= '0;
        rd_q          <= 1'b0;
        first_byte    <= 1'b0;
        read_mode     <= 1'b0;
      end else begin
        // Memory data lands one cycle after the strobe: the first byte of a
        // READ goes straight to the output byte, later ones are prefetched.
        if (rd_q) begin
          if (first_byte) begin
            cur_byte   <= mem_rdata;
            first_byte <= 1'b0;
          end else begin
            nxt_byte <= mem_rdata;
          end
        end
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: if (rise) begin
            shift_in <= shift_next;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              cmd_code <= shift_next[7:0];
              bit_cnt  <= '0;
              obit     <= '0;
              rbit     <= '0;
              case (shift_next[7:0])
                8'h03: state <= ADDR;
                8'h05: begin
                  state    <= DATA;
                  cur_byte <= 8'h00;
                end
                8'hAB: state <= DUMMY;
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (rise) begin
            shift_in <= shift_next;
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              mem_addr   <= shift_next[ADDR_WIDTH-1:0];
              mem_rd     <= 1'b1;
              first_byte <= 1'b1;
              read_mode  <= 1'b1;
              state      <= DATA;
            end
          end
          DUMMY: if (rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              cur_byte <= SILICON_ID;
              state    <= DATA;
            end
          end
          DATA: begin
            if (fall) begin
              epcs_data0_oe <= 1'b1;
              epcs_data0    <= cur_byte[3'd7 - obit];
              obit          <= obit + 3'd1;
              // Byte boundary: READ swaps in the prefetch, status/ID repeat.
              if (obit == 3'd7 && read_mode) cur_byte <= nxt_byte;
            end
            if (rise) begin
              rbit <= rbit + 3'd1;
              // Master is sampling bit 7 of the current byte: prefetch next.
              if (rbit == 3'd0 && read_mode) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
                mem_rd   <= 1'b1;
              end
            end
          end
          default: begin
            epcs_data0    <= 1'b0;
            epcs_data0_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_epcs_flash_responder.sv
module tb_epcs_flash_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dclk = 1'b0, sce = 1'b1, sdo = 1'b0;
  logic data0, data0_oe, mem_rd, busy;
  logic [15:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00, cmd_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];
  logic [15:0] rd_log[$];

  always #5 clk = ~clk;

  epcs_flash_responder #(.ADDR_WIDTH(16), .SILICON_ID(8'h12), .SYNC_STAGES(2)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .epcs_dclk(dclk), .epcs_sce(sce), .epcs_sdo(sdo),
    .epcs_data0(data0), .epcs_data0_oe(data0_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .cmd_code(cmd_code), .busy(busy)
  );

  // Backing memory: data valid the cycle after the strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];
  always @(negedge clk) if (mem_rd) rd_log.push_back(mem_addr);

  // One mode-0 bit: data set while dclk low, sampled by master just before rise.
  task automatic xbit(input logic b, output logic r, output logic o);
    sdo = b;
    repeat (4) @(negedge clk);
    r = data0;
    o = data0_oe;
    dclk = 1'b1;
    repeat (4) @(negedge clk);
    dclk = 1'b0;
  endtask

  task automatic xbyte(input logic [7:0] b, output logic [7:0] r,
                       output logic oe_all, output logic oe_any);
    logic o;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      xbit(b[i], r[i], o);
      oe_all &= o;
      oe_any |= o;
    end
  endtask

  task automatic sel();
    sce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic desel();
    repeat (4) @(negedge clk);
    sce = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Full READ of n bytes from flash address a, checked against the memory
  // array and the expected strobe sequence (initial fetch + one per byte).
  task automatic check_read(input logic [23:0] a, input int n, input string nm);
    logic [7:0] r;
    logic oa, on;
    logic [15:0] ea;
    rd_log.delete();
    sel();
    xbyte(8'h03, r, oa, on);
    xbyte(a[23:16], r, oa, on);
    xbyte(a[15:8], r, oa, on);
    xbyte(a[7:0], r, oa, on);
    for (int i = 0; i < n; i++) begin
      xbyte(8'($urandom), r, oa, on);
      ea = a[15:0] + 16'(i);
      checks++;
      if (r !== mem[ea]) begin
        errors++;
        $display("FAIL %s data byte %0d: got %h expected %h", nm, i, r, mem[ea]);
      end
      checks++;
      if (oa !== 1'b1) begin
        errors++;
        $display("FAIL %s oe byte %0d: got 0 expected 1", nm, i);
      end
    end
    desel();
    checks++;
    if (rd_log.size() != n + 1) begin
      errors++;
      $display("FAIL %s rd count: got %0d expected %0d", nm, rd_log.size(), n + 1);
    end else begin
      for (int j = 0; j <= n; j++) begin
        checks++;
        if (rd_log[j] !== a[15:0] + 16'(j)) begin
          errors++;
          $display("FAIL %s rd addr %0d: got %h expected %h", nm, j, rd_log[j], a[15:0] + 16'(j));
        end
      end
    end
    checks++;
    if (cmd_code !== 8'h03) begin
      errors++;
      $display("FAIL %s cmd_code: got %h expected 03", nm, cmd_code);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({data0, data0_oe, mem_addr, mem_rd, cmd_code, busy} !== 28'h0) begin
      errors++;
      $display("FAIL %s: got d0=%b oe=%b addr=%h rd=%b cmd=%h busy=%b expected all 0",
               nm, data0, data0_oe, mem_addr, mem_rd, cmd_code, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_values");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset_idle");
  endtask

  task automatic test_read_basic();
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h3C;
    mem[16'h0102] = 8'hFF;
    mem[16'h0103] = 8'h00;
    check_read(24'h000100, 4, "read_basic");
  endtask

  task automatic test_read_wrap();
    check_read(24'h00FFFF, 2, "read_wrap");
  endtask

  task automatic test_status();
    logic [7:0] r;
    logic oa, on;
    sel();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL status busy: got %b expected 1", busy); end
    xbyte(8'h05, r, oa, on);
    checks++;
    if (on !== 1'b0 || data0_oe !== 1'b0) begin
      errors++;
      $display("FAIL status early_oe: got %b expected 0", on | data0_oe);
    end
    checks++;
    if (cmd_code !== 8'h05) begin errors++; $display("FAIL status cmd_code: got %h expected 05", cmd_code); end
    for (int i = 0; i < 3; i++) begin
      xbyte(8'($urandom), r, oa, on);
      checks++;
      if (r !== 8'h00 || oa !== 1'b1) begin
        errors++;
        $display("FAIL status byte %0d: got %h oe=%b expected 00 oe=1", i, r, oa);
      end
    end
    desel();
    checks++;
    if (busy !== 1'b0 || data0_oe !== 1'b0) begin
      errors++;
      $display("FAIL status release: got busy=%b oe=%b expected 0 0", busy, data0_oe);
    end
  endtask

  task automatic test_read_id();
    logic [7:0] r;
    logic oa, on;
    rd_log.delete();
    sel();
    xbyte(8'hAB, r, oa, on);
    for (int i = 0; i < 3; i++) xbyte(8'($urandom), r, oa, on);
    checks++;
    if (on !== 1'b0) begin errors++; $display("FAIL read_id dummy_oe: got 1 expected 0"); end
    for (int i = 0; i < 2; i++) begin
      xbyte(8'($urandom), r, oa, on);
      checks++;
      if (r !== 8'h12 || oa !== 1'b1) begin
        errors++;
        $display("FAIL read_id byte %0d: got %h oe=%b expected 12 oe=1", i, r, oa);
      end
    end
    desel();
    checks++;
    if (cmd_code !== 8'hAB) begin errors++; $display("FAIL read_id cmd_code: got %h expected ab", cmd_code); end
    checks++;
    if (rd_log.size() != 0) begin errors++; $display("FAIL read_id mem_rd: got %0d pulses expected 0", rd_log.size()); end
  endtask

  task automatic test_ignore();
    logic [7:0] cmds [5];
    logic [7:0] r, c;
    logic oa, on;
    cmds[0] = 8'h06; cmds[1] = 8'h02; cmds[2] = 8'hD8; cmds[3] = 8'hC7;
    do c = 8'($urandom); while (c == 8'h03 || c == 8'h05 || c == 8'hAB);
    cmds[4] = c;
    for (int k = 0; k < 5; k++) begin
      rd_log.delete();
      sel();
      xbyte(cmds[k], r, oa, on);
      xbyte(8'($urandom), r, oa, on);
      xbyte(8'($urandom), r, oa, on);
      checks++;
      if (on !== 1'b0 || r !== 8'h00) begin
        errors++;
        $display("FAIL ignore %h: got oe=%b data=%h expected oe=0 data=00", cmds[k], on, r);
      end
      desel();
      checks++;
      if (cmd_code !== cmds[k] || rd_log.size() != 0) begin
        errors++;
        $display("FAIL ignore %h cmd/rd: got cmd=%h rd=%0d expected cmd=%h rd=0",
                 cmds[k], cmd_code, rd_log.size(), cmds[k]);
      end
    end
  endtask

  task automatic test_partial_addr();
    logic [7:0] r;
    logic oa, on, o;
    rd_log.delete();
    sel();
    xbyte(8'h03, r, oa, on);
    for (int i = 0; i < 12; i++) xbit(1'($urandom), r, o);
    desel();
    checks++;
    if (rd_log.size() != 0 || data0_oe !== 1'b0) begin
      errors++;
      $display("FAIL partial_addr: got rd=%0d oe=%b expected rd=0 oe=0", rd_log.size(), data0_oe);
    end
    check_read(24'($urandom), 2, "after_partial");
  endtask

  task automatic test_random_reads();
    for (int k = 0; k < 4; k++)
      check_read(24'($urandom), $urandom_range(1, 4), "random_read");
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] r;
    logic oa, on;
    sel();
    xbyte(8'h03, r, oa, on);
    xbyte(8'h00, r, oa, on);
    xbyte(8'h12, r, oa, on);
    xbyte(8'h34, r, oa, on);
    xbyte(8'h00, r, oa, on);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_data");
    rst = 1'b0;
    sce = 1'b1;
    repeat (8) @(negedge clk);
    check_read(24'($urandom), 3, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_status();
    test_read_id();
    test_ignore();
    test_partial_addr();
    test_random_reads();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
